mont_op_sequencer: RTL

//  Initiator side of the montgomery start/done interface. Drives an external montgomery core to run

---
 rtl/mont_op_sequencer_pkg.sv | 20 ++
 rtl/mont_op_sequencer.sv | 117 +++++++++++
 2 files changed

// File: rtl/mont_op_sequencer_pkg.sv
// Shared types and constants for the montgomery operation sequencer.
package mont_op_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 381;

    typedef enum logic [1:0] {
        OP_MUL       = 2'b00,
        OP_TO_MONT   = 2'b01,
        OP_FROM_MONT = 2'b10,
        OP_ILLEGAL   = 2'b11
    } mont_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_FIN   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/mont_op_sequencer.sv
// Initiator for an external montgomery core: sequences one or two core passes
// to perform modular multiply, conversion into and out of the Montgomery domain.
module mont_op_sequencer
    import mont_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_r2,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH-1:0] mm_result,
    input  logic             mm_done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    seq_state_t       state;
    mont_op_t         op_q;
    logic             pass;
    logic [WIDTH-1:0] r2_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            pass     <= 1'b0;
            r2_q     <= '0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= mont_op_t'(op);
                        r2_q <= in_r2;
                        mm_a <= in_a;
                        mm_m <= in_m;
                        pass <= 1'b0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        // Pass-0 second operand selects the operation; pass 1 of MUL uses R^2.
                        case (mont_op_t'(op))
                            OP_MUL: begin
                                mm_b  <= in_b;
                                state <= ST_ISSUE;
                            end
                            OP_TO_MONT: begin
                                mm_b  <= in_r2;
                                state <= ST_ISSUE;
                            end
                            OP_FROM_MONT: begin
                                mm_b  <= ONE;
                                state <= ST_ISSUE;
                            end
                            default: begin
                                err    <= 1'b1;
                                result <= '0;
                                state  <= ST_FIN;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    mm_start <= 1'b1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    mm_start <= 1'b0;
                    if (mm_done) begin
                        if (op_q == OP_MUL && !pass) begin
                            pass  <= 1'b1;
                            mm_a  <= mm_result;
                            mm_b  <= r2_q;
                            state <= ST_ISSUE;
                        end else begin
                            result <= mm_result;
                            done   <= 1'b1;
                            state  <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    // Core results arrive with done already set; the illegal-op path
                    // enters with done low and spends one extra cycle raising it.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
